// File: rtl/alu_flag_stage.sv
// Two-entry flag/result buffer between the adder and its consumers.
// Holds {sum, flags, fwe, cond}, owns the architectural flag register and evaluates the head condition.
module alu_flag_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sum,
  input  logic [4:0]  in_flags,
  input  logic        in_fwe,
  input  logic [3:0]  in_cond,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_cond_true,
  output logic [4:0]  psw,
  output logic [1:0]  count
);

  logic [15:0] sum_q   [2];
  logic [4:0]  flags_q [2];
  logic [3:0]  cond_q  [2];
  logic [1:0]  fwe_q;

  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  cnt;
  logic [4:0]  psw_q;
  logic        push;
  logic        pop;

  logic [15:0] head_sum;
  logic [4:0]  head_flags;
  logic [3:0]  head_cond;
  logic        head_fwe;
  logic [4:0]  f;
  logic        cond_hit;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Entry storage needs no reset: contents are only visible through out_valid gating.
  always_ff @(posedge clk) begin
    if (push) begin
      sum_q[wr_ptr]   <= in_sum;
      flags_q[wr_ptr] <= in_flags;
      cond_q[wr_ptr]  <= in_cond;
      fwe_q[wr_ptr]   <= in_fwe;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      psw_q  <= 5'b00000;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (pop && head_fwe) psw_q <= head_flags;
    end
  end

  assign head_sum   = sum_q[rd_ptr];
  assign head_flags = flags_q[rd_ptr];
  assign head_cond  = cond_q[rd_ptr];
  assign head_fwe   = fwe_q[rd_ptr];

  // Flags in effect for the head: its own if it writes them, otherwise the committed psw.
  assign f = head_fwe ? head_flags : psw_q;

  always_comb begin
    cond_hit = 1'b0;
    case (head_cond)
      4'h0: cond_hit = f[0];
      4'h1: cond_hit = ~f[0];
      4'h2: cond_hit = f[4] ^ f[2];
      4'h3: cond_hit = ~(f[4] ^ f[2]);
      4'h4: cond_hit = f[0] | (f[4] ^ f[2]);
      4'h5: cond_hit = ~(f[0] | (f[4] ^ f[2]));
      4'h6: cond_hit = f[3];
      4'h7: cond_hit = ~f[3];
      4'h8: cond_hit = f[4];
      4'h9: cond_hit = ~f[4];
      4'ha: cond_hit = f[2];
      4'hb: cond_hit = ~f[2];
      4'hc: cond_hit = f[1];
      4'hd: cond_hit = ~f[1];
      4'he: cond_hit = 1'b1;
      4'hf: cond_hit = 1'b0;
      default: cond_hit = 1'b0;
    endcase
  end

  assign out_sum       = out_valid ? head_sum : 16'h0000;
  assign out_cond_true = out_valid & cond_hit;
  assign psw           = psw_q;
  assign count         = cnt;

endmodule
